// File: rtl/glitc_clock_sequencer.sv
// -----------------------------------------------------------------------------
// glitc_clock_sequencer
//
// Control-side sequencer for the GLITC clock generator. Runs in the PSCLK
// domain. It owns the generator's 3-bit control word and phase-control byte.
// It runs MMCM reset / input-select sequences with lock timeouts. It also
// performs multi-step fine phase shifts while tracking the absolute phase
// position modulo PS_WRAP.
//
// Ports:
//   clk_i          control clock, also the MMCM PSCLK
//   rst_n_i        asynchronous active-low reset
//   cmd_i          00 nop, 01 reset MMCMs, 10 select input, 11 phase shift
//   cmd_valid_i    command strobe, accepted when cmd_ready_o is high
//   cmd_ready_o    high only in IDLE
//   sel_i          select target: 0 = direct 25 MHz, 1 = x6.5 multiplier
//   ps_dir_i       shift direction: 1 = increment, 0 = decrement
//   ps_steps_i     shift step count
//   ctrl_o         [0] mmcm reset, [1] mult power-down, [2] clock select
//   status_i       async lock status: [0] sysclk MMCM, [1] mult MMCM
//   phase_ctrl_o   [0] PSEN, [1] PSINCDEC, [7:2] zero
//   phase_ctrl_i   [0] PSDONE (synchronous to clk_i), rest ignored
//   ps_pos_o       current phase position, 0..PS_WRAP-1
//   locked_o       required lock(s) present, synchronized
//   busy_o         high when not IDLE
//   done_o         one-cycle pulse on return to IDLE
//   err_o          sticky: [0] lock timeout, [1] PSDONE timeout, [2] shift refused
// -----------------------------------------------------------------------------
module glitc_clock_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned PS_TIMEOUT   = 255,
    parameter int unsigned PS_WRAP      = 672
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] cmd_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       sel_i,
    input  logic       ps_dir_i,
    input  logic [7:0] ps_steps_i,
    output logic [2:0] ctrl_o,
    input  logic [1:0] status_i,
    output logic [7:0] phase_ctrl_o,
    input  logic [7:0] phase_ctrl_i,
    output logic [9:0] ps_pos_o,
    output logic       locked_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] err_o
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RST_HOLD  = 3'd1;
    localparam logic [2:0] ST_LOCK_WAIT = 3'd2;
    localparam logic [2:0] ST_PS_PULSE  = 3'd3;
    localparam logic [2:0] ST_PS_WAIT   = 3'd4;

    localparam logic [1:0] CMD_NOP    = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SELECT = 2'b10;

    // One shared counter serves reset hold, lock timeout and PSDONE timeout.
    localparam int unsigned MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_CNT = (MAX_A > PS_TIMEOUT) ? MAX_A : PS_TIMEOUT;
    localparam int unsigned CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] PS_LAST   = CNT_W'(PS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [9:0]       POS_LAST  = 10'(PS_WRAP - 1);

    // State registers
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ctrl;
    logic             r_dir;
    logic [7:0]       r_steps;
    logic [9:0]       r_pos;
    logic [2:0]       r_err;
    logic             r_done;
    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;

    // Next-state values
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_ctrl_nxt;
    logic             w_dir_nxt;
    logic [7:0]       w_steps_nxt;
    logic [9:0]       w_pos_nxt;
    logic [2:0]       w_err_nxt;
    logic             w_done_nxt;

    logic             w_req_lock;
    logic             w_locked;
    logic             w_accept;
    logic             w_psdone;
    logic             w_psen;
    logic [9:0]       w_pos_inc;
    logic [9:0]       w_pos_dec;
    logic             w_unused;

    // Only PSDONE is meaningful on the phase-control return byte.
    assign w_psdone = phase_ctrl_i[0];
    assign w_unused = ^phase_ctrl_i[7:1];

    // The multiplier lock only matters while the multiplier is the selected input.
    assign w_req_lock = r_sync2[0] & (r_ctrl[2] ? r_sync2[1] : 1'b1);
    assign w_locked   = w_req_lock & ~r_ctrl[0];
    assign w_accept   = cmd_valid_i & (r_state == ST_IDLE);
    assign w_psen     = (r_state == ST_PS_PULSE);

    assign w_pos_inc = (r_pos == POS_LAST) ? 10'd0 : r_pos + 10'd1;
    assign w_pos_dec = (r_pos == 10'd0) ? POS_LAST : r_pos - 10'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ctrl_nxt  = r_ctrl;
        w_dir_nxt   = r_dir;
        w_steps_nxt = r_steps;
        w_pos_nxt   = r_pos;
        w_err_nxt   = r_err;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_err_nxt = 3'b000;
                    case (cmd_i)
                        CMD_NOP: begin
                            w_done_nxt = 1'b1;
                        end
                        CMD_RESET: begin
                            w_ctrl_nxt[0] = 1'b1;
                            w_cnt_nxt     = '0;
                            w_pos_nxt     = 10'd0;
                            w_state_nxt   = ST_RST_HOLD;
                        end
                        CMD_SELECT: begin
                            // Power the multiplier down whenever it is not the source.
                            w_ctrl_nxt  = {sel_i, ~sel_i, 1'b1};
                            w_cnt_nxt   = '0;
                            w_pos_nxt   = 10'd0;
                            w_state_nxt = ST_RST_HOLD;
                        end
                        default: begin
                            // Phase shift
                            if (ps_steps_i == 8'd0) begin
                                w_done_nxt = 1'b1;
                            end else if (!w_locked) begin
                                w_err_nxt[2] = 1'b1;
                                w_done_nxt   = 1'b1;
                            end else begin
                                w_dir_nxt   = ps_dir_i;
                                w_steps_nxt = ps_steps_i;
                                w_state_nxt = ST_PS_PULSE;
                            end
                        end
                    endcase
                end
            end

            ST_RST_HOLD: begin
                w_pos_nxt = 10'd0;
                if (r_cnt == RST_LAST) begin
                    w_ctrl_nxt[0] = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_LOCK_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            ST_LOCK_WAIT: begin
                if (w_req_lock) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == LOCK_LAST) begin
                    w_err_nxt[0] = 1'b1;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            ST_PS_PULSE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_PS_WAIT;
            end

            ST_PS_WAIT: begin
                // PSDONE takes priority, so it wins against a timeout in the same cycle.
                if (w_psdone) begin
                    w_pos_nxt   = r_dir ? w_pos_inc : w_pos_dec;
                    w_steps_nxt = r_steps - 8'd1;
                    if (r_steps == 8'd1) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_PS_PULSE;
                    end
                end else if (r_cnt == PS_LAST) begin
                    w_err_nxt[1] = 1'b1;
                    w_steps_nxt  = 8'd0;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                // Unreachable encodings recover through a full MMCM reset.
                w_ctrl_nxt[0] = 1'b1;
                w_cnt_nxt     = '0;
                w_pos_nxt     = 10'd0;
                w_state_nxt   = ST_RST_HOLD;
            end
        endcase
    end

    // The reset state is RST_HOLD, so reset release runs the startup sequence.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_RST_HOLD;
            r_cnt   <= '0;
            r_ctrl  <= 3'b011;
            r_dir   <= 1'b0;
            r_steps <= 8'd0;
            r_pos   <= 10'd0;
            r_err   <= 3'b000;
            r_done  <= 1'b0;
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_dir   <= w_dir_nxt;
            r_steps <= w_steps_nxt;
            r_pos   <= w_pos_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
            r_sync1 <= status_i;
            r_sync2 <= r_sync1;
        end
    end

    assign cmd_ready_o  = (r_state == ST_IDLE);
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = r_done;
    assign err_o        = r_err;
    assign ctrl_o       = r_ctrl;
    assign ps_pos_o     = r_pos;
    assign locked_o     = w_locked;
    assign phase_ctrl_o = {6'b000000, r_dir, w_psen};

endmodule
